// File: rtl/pixel_frame_tx.sv
// Frame buffer and streamer feeding a convolution engine.
// Pixels are loaded while idle, streamed out in raster order on start, and the
// engine's result phase is then tracked until all results have been flagged.
module pixel_frame_tx #(
  parameter int unsigned N       = 10,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [$clog2(N*N)-1:0] load_addr,
  input  logic [PIX_W-1:0]       load_r,
  input  logic [PIX_W-1:0]       load_g,
  input  logic [PIX_W-1:0]       load_b,
  input  logic                   start,
  input  logic                   start_add_1,
  output logic [PIX_W-1:0]       pixel_r,
  output logic [PIX_W-1:0]       pixel_g,
  output logic [PIX_W-1:0]       pixel_b,
  output logic                   data_in_en,
  output logic                   result_valid,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   timeout_err
);

  localparam int unsigned NPIX    = N * N;
  localparam int unsigned RES_CNT = (N - 2) * (N - 2);
  localparam int unsigned ADDR_W  = $clog2(NPIX);
  localparam int unsigned RA_W    = ADDR_W + 1;
  localparam int unsigned RC_W    = $clog2(RES_CNT) + 1;
  localparam int unsigned WC_W    = $clog2(TIMEOUT) + 1;
  localparam int unsigned DATA_W  = 3 * PIX_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STREAM   = 3'd1,
    WAIT_RES = 3'd2,
    COLLECT  = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [RA_W-1:0]     rd_addr_q, rd_addr_d;
  logic [RC_W-1:0]     res_cnt_q, res_cnt_d;
  logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   pix_q, pix_d;
  logic                data_in_en_q, data_in_en_d;
  logic                result_valid_q, result_valid_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                timeout_err_q, timeout_err_d;
  logic                mem_we_c;
  logic [DATA_W-1:0]   rd_data_c;

  logic [DATA_W-1:0]   mem [NPIX];

  // Frame buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[load_addr] <= {load_r, load_g, load_b};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    rd_addr_d      = rd_addr_q;
    res_cnt_d      = res_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    pix_d          = '0;
    data_in_en_d   = 1'b0;
    result_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    timeout_err_d  = timeout_err_q;
    busy_d         = 1'b0;
    mem_we_c       = 1'b0;
    rd_data_c      = mem[rd_addr_q[ADDR_W-1:0]];

    case (state_q)
      IDLE: begin
        if (start) begin
          // A write presented together with start is dropped.
          state_d       = STREAM;
          rd_addr_d     = '0;
          timeout_err_d = 1'b0;
        end else if (load_en && (RA_W'(load_addr) < RA_W'(NPIX))) begin
          mem_we_c = 1'b1;
        end
      end
      STREAM: begin
        if (rd_addr_q < RA_W'(NPIX)) begin
          pix_d        = rd_data_c;
          data_in_en_d = 1'b1;
          rd_addr_d    = rd_addr_q + RA_W'(1);
        end else begin
          state_d    = WAIT_RES;
          wait_cnt_d = '0;
        end
      end
      WAIT_RES: begin
        if (start_add_1) begin
          state_d        = COLLECT;
          res_cnt_d      = '0;
          result_valid_d = 1'b1;
        end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      COLLECT: begin
        // Count runs to completion regardless of start_add_1.
        if (res_cnt_q == RC_W'(RES_CNT - 1)) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else begin
          res_cnt_d      = res_cnt_q + RC_W'(1);
          result_valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      rd_addr_q      <= '0;
      res_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      pix_q          <= '0;
      data_in_en_q   <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_addr_q      <= rd_addr_d;
      res_cnt_q      <= res_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      pix_q          <= pix_d;
      data_in_en_q   <= data_in_en_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign pixel_r      = pix_q[DATA_W-1 -: PIX_W];
  assign pixel_g      = pix_q[2*PIX_W-1 -: PIX_W];
  assign pixel_b      = pix_q[PIX_W-1:0];
  assign data_in_en   = data_in_en_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pixel_frame_tx.sv
// Self-checking bench for pixel_frame_tx: a table of result-phase scenarios,
// hand-written reset / collision sequences and randomized frame loads checked
// against an array model of the frame buffer.
module tb_pixel_frame_tx;

  localparam int unsigned N       = 10;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned TIMEOUT = 4096;
  localparam int unsigned NPIX    = N * N;
  localparam int unsigned RES_CNT = (N - 2) * (N - 2);
  localparam int unsigned ADDR_W  = $clog2(NPIX);
  localparam int unsigned DATA_W  = 3 * PIX_W;

  logic                clk = 1'b0;
  logic                reset;
  logic                load_en;
  logic [ADDR_W-1:0]   load_addr;
  logic [PIX_W-1:0]    load_r, load_g, load_b;
  logic                start;
  logic                start_add_1;
  logic [PIX_W-1:0]    pixel_r, pixel_g, pixel_b;
  logic                data_in_en, result_valid, busy, frame_done, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] ref_mem [NPIX];

  typedef struct {
    int dly;      // ticks after WAIT_RES entry before start_add_1 rises
    int hold;     // ticks start_add_1 stays high
    int first;    // expected first result_valid tick (0 = none)
    int cnt;      // expected result_valid cycles
    int done_t;   // expected frame_done tick (0 = none)
    int to_t;     // expected timeout_err tick (0 = none)
    int idle_t;   // expected tick where busy drops
  } res_vec_t;

  res_vec_t vecs [5];

  always #5 clk = ~clk;

  pixel_frame_tx #(.N(N), .PIX_W(PIX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_r       (load_r),
    .load_g       (load_g),
    .load_b       (load_b),
    .start        (start),
    .start_add_1  (start_add_1),
    .pixel_r      (pixel_r),
    .pixel_g      (pixel_g),
    .pixel_b      (pixel_b),
    .data_in_en   (data_in_en),
    .result_valid (result_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s_flags", tag),
          {27'd0, busy, data_in_en, result_valid, frame_done, timeout_err}, 0);
    check($sformatf("%s_pix", tag), {8'd0, pixel_r, pixel_g, pixel_b}, 0);
  endtask

  task automatic load_pixel(input int unsigned addr, input logic [DATA_W-1:0] val);
    load_en   = 1'b1;
    load_addr = ADDR_W'(addr);
    {load_r, load_g, load_b} = val;
    tick();
    load_en = 1'b0;
    if (addr < NPIX) ref_mem[addr] = val;
  endtask

  // Streams one frame from IDLE; inj_at >= 0 pulses start and a load mid-stream,
  // with_load0 presents a write to address 0 together with start.
  task automatic run_stream(input string tag, input int inj_at, input bit with_load0);
    start = 1'b1;
    if (with_load0) begin
      load_en   = 1'b1;
      load_addr = '0;
      {load_r, load_g, load_b} = {3{8'hFF}};
    end
    tick();
    start   = 1'b0;
    load_en = 1'b0;
    check($sformatf("%s_busy_start", tag), busy, 1);
    check($sformatf("%s_den_latency", tag), data_in_en, 0);
    check($sformatf("%s_toerr_clear", tag), timeout_err, 0);
    for (int i = 0; i < int'(NPIX); i++) begin
      if (i == inj_at) begin
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = ADDR_W'(3);
        {load_r, load_g, load_b} = 24'hA5_5A_C3;
      end
      tick();
      start   = 1'b0;
      load_en = 1'b0;
      check($sformatf("%s_den_%0d", tag, i), data_in_en, 1);
      check($sformatf("%s_pix_%0d", tag, i), {8'd0, pixel_r, pixel_g, pixel_b},
            {8'd0, ref_mem[i]});
    end
    tick();
    check($sformatf("%s_den_end", tag), data_in_en, 0);
    check($sformatf("%s_pix_end", tag), {8'd0, pixel_r, pixel_g, pixel_b}, 0);
    check($sformatf("%s_busy_wait", tag), busy, 1);
  endtask

  // Drives the result phase from WAIT_RES entry and checks its timeline.
  task automatic run_result(input string tag, input res_vec_t v);
    int first = 0, last = 0, cnt = 0, done_t = 0, done_cnt = 0, to_t = 0, idle_t = 0;
    start_add_1 = (v.dly == 0);
    for (int t = 1; t <= 4400; t++) begin
      tick();
      if (result_valid) begin
        if (cnt == 0) first = t;
        last = t;
        cnt++;
      end
      if (frame_done) begin
        done_cnt++;
        done_t = t;
      end
      if (timeout_err && to_t == 0) to_t = t;
      start_add_1 = (t >= v.dly) && (t < v.dly + v.hold);
      if (!busy) begin
        idle_t = t;
        break;
      end
    end
    start_add_1 = 1'b0;
    check($sformatf("%s_first_valid", tag), first, v.first);
    check($sformatf("%s_valid_cnt", tag), cnt, v.cnt);
    check($sformatf("%s_valid_contig", tag), (cnt == 0) ? 0 : last - first + 1, v.cnt);
    check($sformatf("%s_done_tick", tag), done_t, v.done_t);
    check($sformatf("%s_done_pulses", tag), done_cnt, (v.done_t != 0) ? 1 : 0);
    check($sformatf("%s_timeout_tick", tag), to_t, v.to_t);
    check($sformatf("%s_idle_tick", tag), idle_t, v.idle_t);
  endtask

  function automatic res_vec_t expect_ok(input int dly, input int hold);
    res_vec_t v;
    v.dly    = dly;
    v.hold   = hold;
    v.first  = dly + 1;
    v.cnt    = int'(RES_CNT);
    v.done_t = dly + 1 + int'(RES_CNT);
    v.to_t   = 0;
    v.idle_t = dly + 2 + int'(RES_CNT);
    return v;
  endfunction

  initial begin
    int cnt_v, cnt_d;
    res_vec_t rv;

    vecs[0] = '{dly: 20,   hold: 1,   first: 21,   cnt: 64, done_t: 85,   to_t: 0,    idle_t: 86};
    vecs[1] = '{dly: 0,    hold: 1,   first: 1,    cnt: 64, done_t: 65,   to_t: 0,    idle_t: 66};
    vecs[2] = '{dly: 5,    hold: 100, first: 6,    cnt: 64, done_t: 70,   to_t: 0,    idle_t: 71};
    vecs[3] = '{dly: 4095, hold: 1,   first: 4096, cnt: 64, done_t: 4160, to_t: 0,    idle_t: 4161};
    vecs[4] = '{dly: 4096, hold: 1,   first: 0,    cnt: 0,  done_t: 0,    to_t: 4096, idle_t: 4096};

    reset       = 1'b1;
    load_en     = 1'b0;
    load_addr   = '0;
    load_r      = '0;
    load_g      = '0;
    load_b      = '0;
    start       = 1'b0;
    start_add_1 = 1'b0;

    // Asynchronous reset before any clock edge.
    #3 reset = 1'b0;
    #1 check_zero("reset_init");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_zero("post_reset");

    // Known ramp frame.
    for (int a = 0; a < int'(NPIX); a++) begin
      load_pixel(a, {PIX_W'(a), PIX_W'(a + 1), PIX_W'(a + 2)});
    end
    // Out-of-range addresses must not write.
    load_pixel(100, 24'h111111);
    load_pixel(127, 24'h222222);

    // Result-phase scenarios.
    for (int k = 0; k < 5; k++) begin
      run_stream($sformatf("tbl%0d", k), -1, 1'b0);
      run_result($sformatf("tbl%0d", k), vecs[k]);
    end
    tick();
    check("timeout_sticky", timeout_err, 1);
    check("timeout_idle", busy, 0);

    // start and load_en mid-stream are ignored.
    run_stream("inject", 40, 1'b0);
    run_result("inject", expect_ok(0, 1));
    run_stream("inject_verify", -1, 1'b0);
    run_result("inject_verify", expect_ok(3, 2));

    // Write together with start is dropped.
    run_stream("start_load", -1, 1'b1);
    run_result("start_load", expect_ok(1, 1));

    // Reset at pixel 37 of the stream.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 37; i++) tick();
    check("pix37", {8'd0, pixel_r, pixel_g, pixel_b}, {8'd0, ref_mem[37]});
    #2 reset = 1'b0;
    #1 check_zero("reset_stream");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_zero("after_reset_stream");
    run_stream("replay", -1, 1'b0);
    run_result("replay", expect_ok(2, 1));

    // Reset in the middle of COLLECT.
    run_stream("rc", -1, 1'b0);
    start_add_1 = 1'b1;
    tick();
    start_add_1 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rc_valid_mid", result_valid, 1);
    #2 reset = 1'b0;
    #1 check_zero("reset_collect");
    tick();
    reset = 1'b1;
    cnt_v = 0;
    cnt_d = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (result_valid) cnt_v++;
      if (frame_done) cnt_d++;
    end
    check("rc_no_valid", cnt_v, 0);
    check("rc_no_done", cnt_d, 0);
    check("rc_idle", busy, 0);
    run_stream("rc_retained", -1, 1'b0);
    run_result("rc_retained", expect_ok(0, 1));

    // Randomized loads, streams and result timing.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 3) != 0) begin
          load_pixel($urandom_range(0, 127), DATA_W'($urandom));
        end else begin
          tick();
        end
      end
      run_stream($sformatf("rnd%0d", r), -1, 1'b0);
      rv = expect_ok(int'($urandom_range(0, 40)), int'($urandom_range(1, 90)));
      run_result($sformatf("rnd%0d", r), rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
